// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 subordinate backed by a word-addressed 64-bit RAM.
// Ports: clk/rst, AW/W/B write channels, AR/R read channels (8-bit IDs).
module axi_mem_slave #(
    parameter logic [63:0] base  = 64'h8000_0000,
    parameter int          words = 65536,
    parameter bit          init  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axi_awid,
    input  logic [63:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [7:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [7:0]  s_axi_arid,
    input  logic [63:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [7:0]  s_axi_rid,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);
    localparam int AW = $clog2(words);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [63:0] mem_q [words] = '{default: (init ? 64'd0 : 64'bx)};

    function automatic logic in_range(input logic [63:0] a);
        return (a >= base) && (((a - base) >> 3) < 64'(words));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
        return AW'((a - base) >> 3);
    endfunction

    function automatic logic wrap_ok(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction

    // An illegal WRAP length falls through to INCR stepping.
    function automatic logic [63:0] next_addr(
        input logic [63:0] a,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [63:0] step;
        logic [63:0] mask;
        step = 64'd1 << size;
        mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        if (burst == 2'b00)
            return a;
        else if (burst == 2'b10 && wrap_ok(len))
            return (a & ~mask) | ((a + step) & mask);
        else
            return a + step;
    endfunction

    // ---------------- write channel ----------------
    w_state_e    w_state_q;
    logic [7:0]  w_id_q;
    logic [63:0] w_addr_q;
    logic [7:0]  w_len_q;
    logic [2:0]  w_size_q;
    logic [1:0]  w_burst_q;
    logic [7:0]  w_cnt_q;
    logic        w_slv_q;
    logic        w_dec_q;
    logic        bvalid_q;
    logic [7:0]  bid_q;
    logic [1:0]  bresp_q;

    logic w_hs, w_in, w_last, w_slv_beat;

    assign s_axi_awready = (w_state_q == W_IDLE) && !rst;
    assign s_axi_wready  = (w_state_q == W_DATA) && !rst;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;

    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign w_in       = in_range(w_addr_q);
    assign w_last     = (w_cnt_q == w_len_q);
    assign w_slv_beat = (s_axi_wlast != w_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_slv_q   <= 1'b0;
            w_dec_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            unique case (w_state_q)
                W_IDLE: if (s_axi_awvalid) begin
                    w_id_q    <= s_axi_awid;
                    w_addr_q  <= s_axi_awaddr;
                    w_len_q   <= s_axi_awlen;
                    w_size_q  <= s_axi_awsize;
                    w_burst_q <= s_axi_awburst;
                    w_cnt_q   <= '0;
                    w_dec_q   <= 1'b0;
                    w_slv_q   <= (s_axi_awsize > 3'd3) ||
                                 (s_axi_awburst == 2'b10 && !wrap_ok(s_axi_awlen));
                    w_state_q <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    w_cnt_q  <= w_cnt_q + 8'd1;
                    w_dec_q  <= w_dec_q | !w_in;
                    w_slv_q  <= w_slv_q | w_slv_beat;
                    // Final response folds in this beat's own errors.
                    if (w_last) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bid_q     <= w_id_q;
                        bresp_q   <= (w_dec_q || !w_in) ? 2'b11 :
                                     (w_slv_q || w_slv_beat) ? 2'b10 : 2'b00;
                    end
                end
                W_RESP: if (s_axi_bready) begin
                    bvalid_q  <= 1'b0;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Out-of-range beats are dropped; RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_hs && w_in) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b])
                    mem_q[word_idx(w_addr_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e    r_state_q;
    logic [63:0] r_addr_q;
    logic [7:0]  r_len_q;
    logic [2:0]  r_size_q;
    logic [1:0]  r_burst_q;
    logic [7:0]  r_cnt_q;
    logic        r_slv_q;
    logic        rvalid_q;
    logic        rlast_q;
    logic [7:0]  rid_q;
    logic [1:0]  rresp_q;
    logic [63:0] rdata_q;

    logic        ar_hs, r_hs, ld_in, ld_slv;
    logic [63:0] ld_addr, ld_data;
    logic [1:0]  ld_resp;

    assign s_axi_arready = (r_state_q == R_IDLE) && !rst;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = rvalid_q && s_axi_rready;

    // Beat source: the AR address on accept, else the stepped address.
    // RAM is sampled before this edge's write lands (read-before-write).
    assign ld_addr = ar_hs ? s_axi_araddr : r_addr_q;
    assign ld_slv  = ar_hs ? ((s_axi_arsize > 3'd3) ||
                              (s_axi_arburst == 2'b10 && !wrap_ok(s_axi_arlen)))
                           : r_slv_q;
    assign ld_in   = in_range(ld_addr);
    assign ld_data = ld_in ? mem_q[word_idx(ld_addr)] : 64'd0;
    assign ld_resp = !ld_in ? 2'b11 : ld_slv ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_slv_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else if (r_state_q == R_IDLE) begin
            if (ar_hs) begin
                rid_q     <= s_axi_arid;
                r_len_q   <= s_axi_arlen;
                r_size_q  <= s_axi_arsize;
                r_burst_q <= s_axi_arburst;
                r_slv_q   <= ld_slv;
                rdata_q   <= ld_data;
                rresp_q   <= ld_resp;
                rlast_q   <= (s_axi_arlen == 8'd0);
                rvalid_q  <= 1'b1;
                r_addr_q  <= next_addr(s_axi_araddr, s_axi_arlen,
                                       s_axi_arsize, s_axi_arburst);
                r_cnt_q   <= 8'd1;
                r_state_q <= R_DATA;
            end
        end else if (r_hs) begin
            if (rlast_q) begin
                rvalid_q  <= 1'b0;
                rlast_q   <= 1'b0;
                r_state_q <= R_IDLE;
            end else begin
                rdata_q  <= ld_data;
                rresp_q  <= ld_resp;
                rlast_q  <= (r_cnt_q == r_len_q);
                r_addr_q <= next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
                r_cnt_q  <= r_cnt_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized bench for axi_mem_slave with a behavioural
// memory/response model and a per-cycle compare process.
module tb_axi_mem_slave;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam longint      WORDS = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awid = '0;
    logic [63:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  arid = '0;
    logic [63:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [7:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    axi_mem_slave #(.base(BASE), .words(65536), .init(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } bresp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    rbeat_t      exp_r[$];
    rbeat_t      obs_r[$];
    int          obs_rcyc[$];
    bresp_t      exp_b[$];
    logic [1:0]  obs_bresp = '0;
    logic [7:0]  obs_bid = '0;
    logic [63:0] mdl [longint];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit inr(input logic [63:0] a);
        return a >= BASE && a < BASE + 64'(WORDS) * 64'd8;
    endfunction

    function automatic longint key(input logic [63:0] a);
        return longint'((a - BASE) / 64'd8);
    endfunction

    function automatic logic [63:0] rd_mdl(input logic [63:0] a);
        return mdl.exists(key(a)) ? mdl[key(a)] : 64'd0;
    endfunction

    function automatic bit len_wraps(input int len);
        return len == 1 || len == 3 || len == 7 || len == 15;
    endfunction

    function automatic logic [63:0] nxt(input logic [63:0] a, input int len,
                                        input int size, input int burst);
        logic [63:0] step;
        logic [63:0] bnd;
        step = 64'd1 << size;
        if (burst == 0) return a;
        if (burst == 2 && len_wraps(len)) begin
            bnd = 64'(len + 1) * step;
            return a - (a % bnd) + ((a + step) % bnd);
        end
        return a + step;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL r_unexpected: rvalid=%b want 0", rvalid);
                end else begin
                    chk("rid", 64'(rid), 64'(exp_r[0].id));
                    chk("rdata", rdata, exp_r[0].data);
                    chk("rresp", 64'(rresp), 64'(exp_r[0].resp));
                    chk("rlast", 64'(rlast), 64'(exp_r[0].last));
                    if (rready) begin
                        obs_r.push_back({rid, rdata, rresp, rlast});
                        obs_rcyc.push_back(cyc);
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_unexpected: bvalid=%b want 0", bvalid);
                end else begin
                    chk("bid", 64'(bid), 64'(exp_b[0].id));
                    chk("bresp", 64'(bresp), 64'(exp_b[0].resp));
                    if (bready) begin
                        obs_bresp = bresp;
                        obs_bid = bid;
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic do_write(input logic [7:0] id, input logic [63:0] addr,
                            input int len, input int size, input int burst,
                            input int bad_last, input int bwait,
                            output int hs_cyc);
        logic [63:0] a;
        logic [63:0] w;
        bit          dec;
        bit          slv;
        bit          h;
        int          t;
        bresp_t      e;
        a = addr;
        dec = 0;
        slv = size > 3 || (burst == 2 && !len_wraps(len));
        for (int i = 0; i <= len; i++) begin
            if (i == bad_last) slv = 1;
            if (!inr(a)) dec = 1;
            else begin
                w = rd_mdl(a);
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                mdl[key(a)] = w;
            end
            a = nxt(a, len, size, burst);
        end
        e.id = id;
        e.resp = dec ? 2'b11 : slv ? 2'b10 : 2'b00;
        exp_b.push_back(e);

        awid = id;
        awaddr = addr;
        awlen = 8'(len);
        awsize = 3'(size);
        awburst = 2'(burst);
        awvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            h = awready;
            step();
            t++;
        end while (!h && t < 50);
        awvalid = 1'b0;
        hs_cyc = cyc;
        chk("aw_hs", 64'(h), 64'd1);

        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(3) == 0) begin
                wvalid = 1'b0;
                step();
            end
            wdata = wd[i];
            wstrb = ws[i];
            wlast = (i == len) ^ (i == bad_last);
            wvalid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                h = wready;
                step();
                t++;
            end while (!h && t < 50);
            chk("w_hs", 64'(h), 64'd1);
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        chk("b_lat", 64'(bvalid), 64'd1);

        for (int i = 0; i < bwait; i++) begin
            step();
            chk("b_hold", 64'(bvalid), 64'd1);
        end
        bready = 1'b1;
        t = 0;
        while (exp_b.size() != 0 && t < 50) begin
            step();
            t++;
        end
        bready = 1'b0;
        chk("b_done", 64'(exp_b.size()), 64'd0);
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [63:0] addr,
                           input int len, input int size, input int burst,
                           output int hs_cyc);
        logic [63:0] a;
        bit          slv;
        bit          h;
        int          t;
        rbeat_t      e;
        obs_r.delete();
        obs_rcyc.delete();
        a = addr;
        slv = size > 3 || (burst == 2 && !len_wraps(len));
        for (int i = 0; i <= len; i++) begin
            e.id = id;
            e.data = inr(a) ? rd_mdl(a) : 64'd0;
            e.resp = !inr(a) ? 2'b11 : slv ? 2'b10 : 2'b00;
            e.last = (i == len);
            exp_r.push_back(e);
            a = nxt(a, len, size, burst);
        end
        arid = id;
        araddr = addr;
        arlen = 8'(len);
        arsize = 3'(size);
        arburst = 2'(burst);
        arvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            h = arready;
            step();
            t++;
        end while (!h && t < 50);
        arvalid = 1'b0;
        hs_cyc = cyc;
        chk("ar_hs", 64'(h), 64'd1);
        chk("r_lat", 64'(rvalid), 64'd1);
    endtask

    // rmode: 0 = rready held high, 1 = toggling, 2 = random
    task automatic do_read(input logic [7:0] id, input logic [63:0] addr,
                           input int len, input int size, input int burst,
                           input int rmode, output int hs_cyc);
        int t;
        ar_send(id, addr, len, size, burst, hs_cyc);
        t = 0;
        while (exp_r.size() != 0 && t < 400) begin
            rready = (rmode == 0) ? 1'b1 :
                     (rmode == 1) ? 1'((t % 2) == 0) : 1'($urandom_range(1));
            step();
            t++;
        end
        rready = 1'b0;
        chk("r_done", 64'(exp_r.size()), 64'd0);
    endtask

    task automatic pin_r(input string nm, input int i, input logic [63:0] d,
                         input logic [1:0] rs, input logic l);
        if (i < obs_r.size()) begin
            chk({nm, "_data"}, obs_r[i].data, d);
            chk({nm, "_resp"}, 64'(obs_r[i].resp), 64'(rs));
            chk({nm, "_last"}, 64'(obs_r[i].last), 64'(l));
        end else begin
            chk({nm, "_beats"}, 64'(obs_r.size()), 64'(i + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t want completion", $time);
        $fatal(1);
    end

    initial begin
        int          hw;
        int          hr;
        int          len;
        int          size;
        int          burst;
        int          bl;
        logic [63:0] a;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_bid_bresp", {54'd0, bid, bresp}, 64'd0);
        chk("rst_rid_rresp", {54'd0, rid, rresp}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_awready", 64'(awready), 64'd1);
        chk("idle_arready", 64'(arready), 64'd1);
        step();

        // single write then read
        wd[0] = 64'h1122334455667788;
        ws[0] = 8'hFF;
        do_write(8'h05, 64'h8000_0010, 0, 3, 1, -1, 0, hw);
        chk("t1_bresp", 64'(obs_bresp), 64'd0);
        do_read(8'h3C, 64'h8000_0010, 0, 3, 1, 0, hr);
        pin_r("t1", 0, 64'h1122334455667788, 2'b00, 1'b1);
        if (obs_r.size() > 0) chk("t1_rid", 64'(obs_r[0].id), 64'h3C);

        // INCR preload and read back, full throughput then stalled
        for (int i = 0; i < 4; i++) begin
            wd[i] = 64'hA0 + 64'(i);
            ws[i] = 8'hFF;
        end
        do_write(8'h01, BASE, 3, 3, 1, -1, 0, hw);
        do_read(8'h02, BASE, 3, 3, 1, 0, hr);
        for (int i = 0; i < 4; i++)
            pin_r("incr", i, 64'hA0 + 64'(i), 2'b00, 1'(i == 3));
        if (obs_rcyc.size() == 4)
            chk("incr_b2b", 64'(obs_rcyc[3] - obs_rcyc[0]), 64'd3);
        do_read(8'h02, BASE, 3, 3, 1, 1, hr);
        for (int i = 0; i < 4; i++)
            pin_r("stall", i, 64'hA0 + 64'(i), 2'b00, 1'(i == 3));

        // WRAP read 0x10, 0x18, 0x00, 0x08
        do_read(8'h03, 64'h8000_0010, 3, 3, 2, 0, hr);
        pin_r("wrap0", 0, 64'hA2, 2'b00, 1'b0);
        pin_r("wrap1", 1, 64'hA3, 2'b00, 1'b0);
        pin_r("wrap2", 2, 64'hA0, 2'b00, 1'b0);
        pin_r("wrap3", 3, 64'hA1, 2'b00, 1'b1);

        // strobed write over a zero word
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        ws[0] = 8'h0F;
        do_write(8'h04, 64'h8000_0100, 0, 3, 1, -1, 0, hw);
        do_read(8'h04, 64'h8000_0100, 0, 3, 1, 0, hr);
        pin_r("strb", 0, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1);

        // errors
        do_read(8'h06, 64'h7FFF_FFF8, 0, 3, 1, 0, hr);
        pin_r("decerr", 0, 64'd0, 2'b11, 1'b1);
        wd[0] = 64'h1;
        wd[1] = 64'h2;
        ws[0] = 8'hFF;
        ws[1] = 8'hFF;
        do_write(8'h07, 64'h8000_0200, 1, 4, 1, -1, 0, hw);
        chk("size4_bresp", 64'(obs_bresp), 64'd2);
        wd[2] = 64'h3;
        ws[2] = 8'hFF;
        do_write(8'h08, 64'h8000_0240, 2, 3, 1, 1, 0, hw);
        chk("wlast_bresp", 64'(obs_bresp), 64'd2);

        // concurrent AW and AR, B stalled 5 cycles
        wd[0] = 64'hC0FFEE;
        ws[0] = 8'hFF;
        fork
            do_write(8'h77, 64'h8000_0300, 0, 3, 1, -1, 5, hw);
            do_read(8'h55, BASE, 1, 3, 1, 2, hr);
        join
        chk("conc_same_cycle", 64'(hw), 64'(hr));
        chk("conc_bid", 64'(obs_bid), 64'h77);

        // reset mid 8-beat read
        ar_send(8'h09, BASE, 7, 3, 1, hr);
        rready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        exp_r.delete();
        step();
        chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
        chk("rst_mid_arready", 64'(arready), 64'd0);
        rready = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_after_arready", 64'(arready), 64'd1);
        step();
        do_read(8'h0A, BASE, 0, 3, 1, 0, hr);
        pin_r("rst_keep", 0, 64'hA0, 2'b00, 1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            len = ($urandom_range(1) == 0) ? $urandom_range(3) : $urandom_range(15);
            size = ($urandom_range(3) == 0) ? $urandom_range(4) : 3;
            burst = $urandom_range(2);
            case ($urandom_range(5))
                0: a = BASE + 64'(WORDS) * 64'd8 - 64'd8 * 64'($urandom_range(1, 4));
                1: a = BASE - 64'd8 * 64'($urandom_range(1, 3));
                default: a = BASE + 64'($urandom_range(511));
            endcase
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wd[i] = {$urandom, $urandom};
                    ws[i] = 8'($urandom);
                end
                bl = ($urandom_range(7) == 0) ? $urandom_range(len) : -1;
                do_write(8'($urandom), a, len, size, burst, bl,
                         $urandom_range(3), hw);
            end else begin
                do_read(8'($urandom), a, len, size, burst, 2, hr);
            end
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
